// File: rtl/vivo_fifo_flex_if.sv
//------------------------------------------------------------------------------
// Module   : vivo_fifo_flex_if
// Brief    : Push/pop handshake and status bundle for the variable-width FIFO.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface vivo_fifo_flex_if #(
    parameter int ELEM_WIDTH    = 8,
    parameter int DEPTH         = 64,
    parameter int IN_ELEMS_MAX  = 4,
    parameter int OUT_ELEMS_MAX = 4
) ();
    localparam int INW = $clog2(IN_ELEMS_MAX + 1);
    localparam int OUTW = $clog2(OUT_ELEMS_MAX + 1);
    localparam int CW = $clog2(DEPTH + 1);

    logic                                  flush;
    logic                                  in_valid;
    logic                                  in_ready;
    logic [IN_ELEMS_MAX*ELEM_WIDTH-1:0]    in_data;
    logic [INW-1:0]                        in_num_elems;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [OUT_ELEMS_MAX*ELEM_WIDTH-1:0]   out_data;
    logic [OUTW-1:0]                       out_num_elems;
    logic [OUTW-1:0]                       out_req_elems;
    logic [CW-1:0]                         level;
    logic                                  almost_full;
    logic                                  almost_empty;

    modport master (
        output flush, in_valid, in_data, in_num_elems, out_ready, out_req_elems,
        input  in_ready, out_valid, out_data, out_num_elems, level,
               almost_full, almost_empty
    );

    modport slave (
        input  flush, in_valid, in_data, in_num_elems, out_ready, out_req_elems,
        output in_ready, out_valid, out_data, out_num_elems, level,
               almost_full, almost_empty
    );
endinterface

`default_nettype wire

// File: rtl/vivo_fifo_flex.sv
//------------------------------------------------------------------------------
// Module   : vivo_fifo_flex
// Brief    : Variable-in / variable-out element FIFO on a circular store of any DEPTH.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module vivo_fifo_flex #(
    parameter int ELEM_WIDTH    = 8,
    parameter int DEPTH         = 64,
    parameter int IN_ELEMS_MAX  = 4,
    parameter int OUT_ELEMS_MAX = 4,
    parameter int PARTIAL_POP   = 0,
    parameter int AF_THRESH     = DEPTH - IN_ELEMS_MAX,
    parameter int AE_THRESH     = OUT_ELEMS_MAX - 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    vivo_fifo_flex_if.slave    bus
);
    localparam int OUTW = $clog2(OUT_ELEMS_MAX + 1);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW   = CW + 1;

    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic [CW-1:0]          r_count;
    logic [ELEM_WIDTH-1:0]  r_mem [DEPTH];

    logic [SW-1:0] w_in_n;
    logic [SW-1:0] w_space;
    logic          w_in_ready;
    logic          w_push;
    logic [SW-1:0] w_req;
    logic [SW-1:0] w_grant_raw;
    logic [SW-1:0] w_grant;
    logic          w_pop;
    logic [SW-1:0] w_push_n;
    logic [SW-1:0] w_pop_n;
    logic [OUT_ELEMS_MAX*ELEM_WIDTH-1:0] w_out_data;

    // Operands never exceed 2*DEPTH-1, so one conditional subtract wraps.
    function automatic logic [PW-1:0] f_wrap(input logic [SW-1:0] sum);
        if (sum >= SW'(DEPTH)) begin
            return PW'(sum - SW'(DEPTH));
        end
        return PW'(sum);
    endfunction

    assign w_in_n     = SW'(bus.in_num_elems);
    assign w_space    = SW'(DEPTH) - SW'(r_count);
    assign w_in_ready = !rst && !bus.flush && (w_in_n != '0)
                        && (w_in_n <= SW'(IN_ELEMS_MAX)) && (w_in_n <= w_space);
    assign w_push     = bus.in_valid && w_in_ready;

    assign w_req = (SW'(bus.out_req_elems) > SW'(OUT_ELEMS_MAX)) ? SW'(OUT_ELEMS_MAX)
                                                                 : SW'(bus.out_req_elems);

    generate
        if (PARTIAL_POP != 0) begin : g_partial
            assign w_grant_raw = (w_req <= SW'(r_count)) ? w_req : SW'(r_count);
        end else begin : g_strict
            assign w_grant_raw = (w_req <= SW'(r_count)) ? w_req : '0;
        end
    endgenerate

    assign w_grant  = (rst || bus.flush) ? '0 : w_grant_raw;
    assign w_pop    = (w_grant != '0) && bus.out_ready;
    assign w_push_n = w_push ? w_in_n : '0;
    assign w_pop_n  = w_pop ? w_grant : '0;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_wrap(SW'(r_wr_ptr) + w_in_n);
            end
            if (w_pop) begin
                r_rd_ptr <= f_wrap(SW'(r_rd_ptr) + w_grant);
            end
            r_count <= CW'(SW'(r_count) + w_push_n - w_pop_n);
        end
    end

    // Storage is not reset; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            for (int k = 0; k < IN_ELEMS_MAX; k++) begin
                if (SW'(k) < w_in_n) begin
                    r_mem[f_wrap(SW'(r_wr_ptr) + SW'(k))] <= bus.in_data[k*ELEM_WIDTH +: ELEM_WIDTH];
                end
            end
        end
    end

    always_comb begin
        w_out_data = '0;
        for (int i = 0; i < OUT_ELEMS_MAX; i++) begin
            if (SW'(i) < w_grant) begin
                w_out_data[i*ELEM_WIDTH +: ELEM_WIDTH] = r_mem[f_wrap(SW'(r_rd_ptr) + SW'(i))];
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = (w_grant != '0);
    assign bus.out_num_elems = OUTW'(w_grant);
    assign bus.out_data      = w_out_data;
    assign bus.level         = r_count;
    assign bus.almost_full   = (SW'(r_count) >= SW'(AF_THRESH));
    assign bus.almost_empty  = (SW'(r_count) <= SW'(AE_THRESH));

endmodule

`default_nettype wire

// File: tb/tb_vivo_fifo_flex.sv
//------------------------------------------------------------------------------
// Module   : tb_vivo_fifo_flex
// Brief    : Directed bench driving a strict-grant and a partial-grant FIFO in lockstep.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vivo_fifo_flex;
    localparam int EW = 8;
    localparam int D  = 10;
    localparam int NI = 4;
    localparam int NO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic [2:0]  in_num = '0;
    logic [2:0]  out_req = '0;
    logic        out_ready = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    vivo_fifo_flex_if #(.ELEM_WIDTH(EW), .DEPTH(D), .IN_ELEMS_MAX(NI), .OUT_ELEMS_MAX(NO)) ifa ();
    vivo_fifo_flex_if #(.ELEM_WIDTH(EW), .DEPTH(D), .IN_ELEMS_MAX(NI), .OUT_ELEMS_MAX(NO)) ifb ();

    assign ifa.flush = flush;          assign ifb.flush = flush;
    assign ifa.in_valid = in_valid;    assign ifb.in_valid = in_valid;
    assign ifa.in_data = in_data;      assign ifb.in_data = in_data;
    assign ifa.in_num_elems = in_num;  assign ifb.in_num_elems = in_num;
    assign ifa.out_ready = out_ready;  assign ifb.out_ready = out_ready;
    assign ifa.out_req_elems = out_req; assign ifb.out_req_elems = out_req;

    vivo_fifo_flex #(.ELEM_WIDTH(EW), .DEPTH(D), .IN_ELEMS_MAX(NI), .OUT_ELEMS_MAX(NO),
                     .PARTIAL_POP(0)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
    vivo_fifo_flex #(.ELEM_WIDTH(EW), .DEPTH(D), .IN_ELEMS_MAX(NI), .OUT_ELEMS_MAX(NO),
                     .PARTIAL_POP(1)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_push(input logic v, input int base, input int n);
        in_valid = v;
        in_num   = 3'(n);
        for (int k = 0; k < NI; k++) begin
            in_data[k*EW +: EW] = 8'(base + k);
        end
    endtask

    initial begin
        // Reset with traffic offered
        rst = 1'b1; set_push(1'b1, 0, 3); out_req = 3'd4; out_ready = 1'b1;
        tick; tick;
        check("rst_in_ready",  32'(ifa.in_ready), 32'd0);
        check("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        check("rst_out_data",  ifa.out_data, 32'd0);
        check("rst_out_num",   32'(ifa.out_num_elems), 32'd0);

        rst = 1'b0; set_push(1'b0, 0, 0); out_req = 3'd0; out_ready = 1'b0;
        #1;
        check("post_rst_level",  32'(ifa.level), 32'd0);
        check("rdy_n0",          32'(ifa.in_ready), 32'd0);
        check("post_rst_ae",     32'(ifa.almost_empty), 32'd1);
        check("post_rst_af",     32'(ifa.almost_full), 32'd0);
        set_push(1'b0, 0, 5); #1;
        check("rdy_n5",          32'(ifa.in_ready), 32'd0);

        // Fill with 0..9 in chunks 3,3,3,1
        set_push(1'b1, 0, 3); #1; check("rdy_push0", 32'(ifa.in_ready), 32'd1); tick;
        set_push(1'b1, 3, 3); tick;
        set_push(1'b1, 6, 3); tick;
        set_push(1'b1, 9, 2); #1;
        check("level9",       32'(ifa.level), 32'd9);
        check("rdy_n2_lvl9",  32'(ifa.in_ready), 32'd0);
        set_push(1'b1, 9, 1); #1;
        check("rdy_n1_lvl9",  32'(ifa.in_ready), 32'd1);
        tick;
        set_push(1'b0, 0, 1); #1;
        check("level10",      32'(ifa.level), 32'd10);
        check("af_full",      32'(ifa.almost_full), 32'd1);
        check("rdy_full",     32'(ifa.in_ready), 32'd0);

        // Push 2 with pop 4 at full: push blocked this cycle
        set_push(1'b1, 10, 2); out_req = 3'd4; out_ready = 1'b1; #1;
        check("rdy_simul_full", 32'(ifa.in_ready), 32'd0);
        check("pop1_num",       32'(ifa.out_num_elems), 32'd4);
        check("pop1_data",      ifa.out_data, 32'h03020100);
        tick;
        check("level6",         32'(ifa.level), 32'd6);
        check("rdy_simul_lvl6", 32'(ifa.in_ready), 32'd1);
        check("pop2_data",      ifa.out_data, 32'h07060504);
        tick;
        set_push(1'b1, 12, 1); #1;
        check("level4",         32'(ifa.level), 32'd4);
        check("pop3_wrap_data", ifa.out_data, 32'h0b0a0908);
        tick;

        // One element left: strict withholds, partial grants 1
        set_push(1'b0, 0, 0); out_ready = 1'b0; #1;
        check("level1",        32'(ifa.level), 32'd1);
        check("ae_lvl1",       32'(ifa.almost_empty), 32'd1);
        check("a_valid_lvl1",  32'(ifa.out_valid), 32'd0);
        check("a_data_lvl1",   ifa.out_data, 32'd0);
        check("b_num_lvl1",    32'(ifb.out_num_elems), 32'd1);
        check("b_data_lvl1",   ifb.out_data, 32'h0000000c);

        set_push(1'b1, 13, 1); tick;
        set_push(1'b0, 0, 0); #1;
        check("a_valid_lvl2",  32'(ifa.out_valid), 32'd0);
        check("b_num_lvl2",    32'(ifb.out_num_elems), 32'd2);
        check("b_data_lvl2",   ifb.out_data, 32'h00000d0c);
        out_req = 3'd2; #1;
        check("a_num_req2",    32'(ifa.out_num_elems), 32'd2);
        check("a_data_req2",   ifa.out_data, 32'h00000d0c);
        out_ready = 1'b1; tick;
        out_ready = 1'b0; out_req = 3'd0; #1;
        check("a_level_drain", 32'(ifa.level), 32'd0);
        check("b_level_drain", 32'(ifb.level), 32'd0);

        // Back-pressure with oversize request, then flush
        set_push(1'b1, 20, 4); tick;
        set_push(1'b1, 24, 3); tick;
        set_push(1'b0, 0, 0); out_req = 3'd7; #1;
        check("level7",        32'(ifa.level), 32'd7);
        check("af_lvl7",       32'(ifa.almost_full), 32'd1);
        check("ae_lvl7",       32'(ifa.almost_empty), 32'd0);
        check("req_clamp_num", 32'(ifa.out_num_elems), 32'd4);
        for (int c = 0; c < 5; c++) begin
            check("hold_data", ifa.out_data, 32'h17161514);
            tick;
        end
        flush = 1'b1; set_push(1'b1, 30, 1); #1;
        check("flush_rdy",     32'(ifa.in_ready), 32'd0);
        check("flush_valid",   32'(ifa.out_valid), 32'd0);
        tick;
        flush = 1'b0; set_push(1'b0, 0, 0); out_req = 3'd4; #1;
        check("a_level_flush", 32'(ifa.level), 32'd0);
        check("b_level_flush", 32'(ifb.level), 32'd0);
        check("valid_flush",   32'(ifa.out_valid), 32'd0);

        // Reset with push and pop offered
        set_push(1'b1, 8'h40, 3); tick;
        set_push(1'b1, 8'h50, 3); out_req = 3'd4; out_ready = 1'b1; rst = 1'b1;
        tick;
        rst = 1'b0; set_push(1'b0, 0, 0); out_ready = 1'b0; #1;
        check("a_level_rst", 32'(ifa.level), 32'd0);
        check("b_level_rst", 32'(ifb.level), 32'd0);
        set_push(1'b1, 8'h60, 1); tick;
        set_push(1'b0, 0, 0); out_req = 3'd1; #1;
        check("post_rst_num",  32'(ifa.out_num_elems), 32'd1);
        check("post_rst_data", ifa.out_data, 32'h00000060);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
